// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read-master sequencer: splits a byte-addressed read command into capped,
// 4 KB-safe INCR bursts, forwards R beats downstream and reports one response.
module axi_rd_burst_ctrl #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_address,
    input  logic [15:0]       cmd_bytes,
    output logic              busy,
    output logic              done_valid,
    output logic [1:0]        done_resp,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
);
    localparam int unsigned BEAT_BYTES = DATA_W / 8;
    localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int unsigned REM_W      = 17;
    localparam int unsigned CNT_W      = 9;
    localparam logic [31:0] ADDR_MASK  = ~(32'(BEAT_BYTES - 1));
    localparam logic [1:0]  RESP_OKAY  = 2'd0;
    localparam logic [1:0]  RESP_SLV   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [REM_W-1:0]   r_remaining;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [1:0]         r_err;
    logic [31:0]        r_araddr;
    logic [7:0]         r_arlen;
    logic               r_arvalid;
    logic               r_busy;
    logic               r_done_valid;
    logic [1:0]         r_done_resp;

    state_t             w_state_next;
    logic [31:0]        w_addr_next;
    logic [REM_W-1:0]   w_rem_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [1:0]         w_err_next;
    logic [REM_W-1:0]   w_beats;
    logic [REM_W-1:0]   w_room;
    logic [REM_W-1:0]   w_burst_n;
    logic               w_r_hs;
    logic               w_final;

    assign w_beats = (17'(cmd_bytes) + 17'(BEAT_BYTES - 1)) >> BEAT_SHIFT;
    assign w_r_hs  = (r_state == ST_R) && rvalid && out_ready;
    assign w_final = (r_beat_cnt == 9'd1);

    // Next-state, datapath and aggregated-error update
    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_rem_next   = r_remaining;
        w_cnt_next   = r_beat_cnt;
        w_err_next   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid && !rst) begin
                    w_addr_next  = cmd_address & ADDR_MASK;
                    w_rem_next   = w_beats;
                    w_err_next   = RESP_OKAY;
                    w_state_next = (w_beats == 17'd0) ? ST_DONE : ST_AR;
                end
            end
            ST_AR: begin
                if (arready && r_arvalid) begin
                    w_cnt_next   = 9'(r_arlen) + 9'd1;
                    w_state_next = ST_R;
                end
            end
            ST_R: begin
                if (w_r_hs) begin
                    w_cnt_next = r_beat_cnt - 9'd1;
                    w_rem_next = r_remaining - 17'd1;
                    // only the first error sticks; rlast misuse counts as a slave error
                    if (r_err == RESP_OKAY) begin
                        if (rresp[1]) begin
                            w_err_next = rresp;
                        end else if (rlast != w_final) begin
                            w_err_next = RESP_SLV;
                        end
                    end
                    if (w_final) begin
                        if (w_err_next != RESP_OKAY) begin
                            w_state_next = ST_DONE;
                        end else if (w_rem_next != 17'd0) begin
                            w_addr_next  = r_addr + ((32'(r_arlen) + 32'd1) << BEAT_SHIFT);
                            w_state_next = ST_AR;
                        end else begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Burst size: min(remaining, MAX_LEN, beats left in the 4 KB page)
    assign w_room = (17'd4096 - 17'(w_addr_next[11:0])) >> BEAT_SHIFT;

    always_comb begin
        w_burst_n = w_rem_next;
        if (w_burst_n > 17'(MAX_LEN)) begin
            w_burst_n = 17'(MAX_LEN);
        end
        if (w_burst_n > w_room) begin
            w_burst_n = w_room;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= 32'd0;
            r_remaining  <= 17'd0;
            r_beat_cnt   <= 9'd0;
            r_err        <= RESP_OKAY;
            r_araddr     <= 32'd0;
            r_arlen      <= 8'd0;
            r_arvalid    <= 1'b0;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_resp  <= RESP_OKAY;
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_remaining  <= w_rem_next;
            r_beat_cnt   <= w_cnt_next;
            r_err        <= w_err_next;
            r_arvalid    <= (w_state_next == ST_AR);
            r_busy       <= (w_state_next != ST_IDLE);
            r_done_valid <= (w_state_next == ST_DONE);
            if (w_state_next == ST_DONE) begin
                r_done_resp <= w_err_next;
            end
            // AR fields are captured once on entry so they stay put under back-pressure
            if ((w_state_next == ST_AR) && (r_state != ST_AR)) begin
                r_araddr <= w_addr_next;
                r_arlen  <= 8'(w_burst_n - 17'd1);
            end
        end
    end

    assign cmd_ready  = (r_state == ST_IDLE) && !rst;
    assign busy       = r_busy;
    assign done_valid = r_done_valid;
    assign done_resp  = r_done_resp;
    assign araddr     = r_araddr;
    assign arlen      = r_arlen;
    assign arsize     = 3'(BEAT_SHIFT);
    assign arburst    = 2'b01;
    assign arvalid    = r_arvalid;
    assign rready     = (r_state == ST_R) && out_ready;
    assign out_data   = rdata;
    assign out_valid  = (r_state == ST_R) && rvalid;
    assign out_last   = (r_state == ST_R) && rvalid && (r_remaining == 17'd1);

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
// Self-checking bench for axi_rd_burst_ctrl: directed vector table, reset sequence
// and randomized commands against a burst-list reference model with an R slave.
module tb_axi_rd_burst_ctrl;
    localparam int unsigned DW   = 64;
    localparam int unsigned BB   = DW / 8;
    localparam int unsigned ML   = 16;
    localparam int          NVEC = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [31:0]   cmd_address = 32'd0;
    logic [15:0]   cmd_bytes = 16'd0;
    logic          busy;
    logic          done_valid;
    logic [1:0]    done_resp;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'd0;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b0;

    always #5 clk = ~clk;

    axi_rd_burst_ctrl #(.DATA_W(DW), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_address(cmd_address), .cmd_bytes(cmd_bytes),
        .busy(busy), .done_valid(done_valid), .done_resp(done_resp),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
    );

    int total = 0;
    int bad   = 0;

    // Reference model results
    int unsigned exp_addr[$];
    int unsigned exp_len[$];
    int          exp_total_beats;
    int          exp_nb;
    int          exp_beats;
    logic [1:0]  exp_resp;

    // Slave fault injection: global beat indices
    int          inj_e1 = -1;
    logic [1:0]  inj_r1 = 2'd0;
    int          inj_e2 = -1;
    logic [1:0]  inj_r2 = 2'd0;
    int          inj_flip = -1;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] nbytes;
        int          e1;
        logic [1:0]  r1;
        int          e2;
        logic [1:0]  r2;
        int          flip;
        int          stall;
        int          x_nar;
        logic [31:0] x_addr;
        logic [7:0]  x_len;
        int          x_beats;
        logic [1:0]  x_resp;
    } vec_t;

    vec_t vt[NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] resp_at(input int g);
        if (g == inj_e1) return inj_r1;
        if (g == inj_e2) return inj_r2;
        return 2'd0;
    endfunction

    function automatic logic [63:0] beat_data(input int g);
        return {32'hD00D_0000 + 32'(g), 32'(g) * 32'h9E37_79B9};
    endfunction

    // Burst list from the splitting rules, then truncate at the first failing burst
    task automatic build_model(input logic [31:0] a, input logic [15:0] nbytes);
        int unsigned cur, left, n, room;
        int          g;
        logic [1:0]  err;
        exp_addr.delete();
        exp_len.delete();
        cur  = a - (a % BB);
        left = (int'(nbytes) + BB - 1) / BB;
        exp_total_beats = int'(left);
        while (left > 0) begin
            n = left;
            if (n > ML) n = ML;
            room = (4096 - (cur % 4096)) / BB;
            if (n > room) n = room;
            exp_addr.push_back(cur);
            exp_len.push_back(n - 1);
            cur  += n * BB;
            left -= n;
        end
        err = 2'd0;
        g = 0;
        exp_nb = 0;
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (err != 2'd0) break;
            exp_nb++;
            for (int k = 0; k <= int'(exp_len[i]); k++) begin
                if (err == 2'd0 && resp_at(g) >= 2'd2) err = resp_at(g);
                else if (err == 2'd0 && g == inj_flip) err = 2'd2;
                g++;
            end
        end
        exp_beats = g;
        exp_resp  = err;
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [15:0] nbytes,
                           input int ar_stall, input int abort_at,
                           output int n_ar, output logic [31:0] first_addr,
                           output logic [7:0] first_len, output int n_beats,
                           output logic [1:0] resp_seen);
        int unsigned sq_len[$];
        int unsigned beat_in;
        int          g, done_cyc, need_ar_cyc, stall_cnt;
        logic        prev_stall, in_r, finished, quiet, have_burst;
        logic [31:0] prev_addr;
        logic [7:0]  prev_len;
        build_model(a, nbytes);
        n_ar = 0; first_addr = 32'd0; first_len = 8'd0; n_beats = 0; resp_seen = 2'd0;
        beat_in = 0; g = 0; stall_cnt = 0; prev_stall = 1'b0; finished = 1'b0;
        prev_addr = 32'd0; prev_len = 8'd0;
        done_cyc    = (exp_nb == 0) ? 0 : -1;
        need_ar_cyc = (exp_nb == 0) ? -1 : 0;
        cmd_valid = 1'b1; cmd_address = a; cmd_bytes = nbytes;
        arready = 1'b0; rvalid = 1'b0; out_ready = 1'b0;
        #1;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            if (abort_at >= 0 && g == abort_at) begin
                n_beats = g;
                return;
            end
            quiet = (done_cyc >= 0) && (cyc > done_cyc);
            cmd_valid   = quiet ? 1'b0 : ($urandom_range(0, 3) == 0);
            cmd_address = $urandom;
            cmd_bytes   = 16'($urandom);
            if (ar_stall > 0) arready = arvalid && (stall_cnt >= ar_stall);
            else              arready = ($urandom_range(0, 2) != 0);
            have_burst = (sq_len.size() > 0);
            rvalid = have_burst && ($urandom_range(0, 4) != 0);
            rdata  = beat_data(g);
            rresp  = resp_at(g);
            rlast  = (have_burst ? (beat_in == sq_len[0]) : 1'b0) ^ (g == inj_flip);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            in_r = busy && !arvalid && !done_valid;
            chk("done_valid", 64'(done_valid), 64'(cyc == done_cyc));
            if (cyc == done_cyc) begin
                chk("done_resp", 64'(done_resp), 64'(exp_resp));
                resp_seen = done_resp;
            end
            chk("busy", 64'(busy), 64'(done_cyc < 0 || cyc <= done_cyc));
            chk("cmd_ready", 64'(cmd_ready), 64'(done_cyc >= 0 && cyc > done_cyc));
            if (cyc == need_ar_cyc) chk("arvalid_timely", 64'(arvalid), 64'(1));
            if (prev_stall) begin
                chk("ar_hold_valid", 64'(arvalid), 64'(1));
                chk("ar_hold_addr", 64'(araddr), 64'(prev_addr));
                chk("ar_hold_len", 64'(arlen), 64'(prev_len));
            end
            if (arvalid) chk("ar_allowed", 64'(n_ar < exp_nb), 64'(1));
            chk("rready", 64'(rready), 64'(in_r && out_ready));
            chk("out_valid", 64'(out_valid), 64'(in_r && rvalid));
            if (arvalid && arready) begin
                if (n_ar < exp_nb) begin
                    chk("araddr", 64'(araddr), 64'(exp_addr[n_ar]));
                    chk("arlen", 64'(arlen), 64'(exp_len[n_ar]));
                end
                if (n_ar == 0) begin
                    first_addr = araddr;
                    first_len  = arlen;
                end
                sq_len.push_back(32'(arlen));
                n_ar++;
                stall_cnt  = 0;
                prev_stall = 1'b0;
            end else begin
                prev_stall = arvalid;
                prev_addr  = araddr;
                prev_len   = arlen;
                if (arvalid) stall_cnt++;
            end
            if (rvalid && rready) begin
                chk("out_data", out_data, beat_data(g));
                chk("out_last", 64'(out_last), 64'(g == exp_total_beats - 1));
                beat_in++;
                g++;
                if (beat_in > sq_len[0]) begin
                    void'(sq_len.pop_front());
                    beat_in = 0;
                    if (g == exp_beats) done_cyc = cyc + 1;
                    else                need_ar_cyc = cyc + 1;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                finished = 1'b1;
                n_beats  = g;
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!finished) chk("timeout", 64'(0), 64'(1));
        cmd_valid = 1'b0; arready = 1'b0; rvalid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic check_reset_values(input logic exp_cmd_ready);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(exp_cmd_ready));
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_rready", 64'(rready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_done_valid", 64'(done_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done_resp", 64'(done_resp), 64'(0));
        chk("rst_araddr", 64'(araddr), 64'(0));
        chk("rst_arlen", 64'(arlen), 64'(0));
    endtask

    int          n_ar, n_beats;
    logic [31:0] f_addr, a_rnd;
    logic [7:0]  f_len;
    logic [1:0]  resp;

    initial begin
        //           addr          bytes    e1 r1    e2 r2    flip stall nar  x_addr      len    beats resp
        vt[0]  = '{32'h0000_1000, 16'd64,   -1, 2'd0, -1, 2'd0, -1,  5,    1, 32'h1000,  8'd7,  8,    2'd0};
        vt[1]  = '{32'h0000_0000, 16'd200,  -1, 2'd0, -1, 2'd0, -1,  0,    2, 32'h0000,  8'd15, 25,   2'd0};
        vt[2]  = '{32'h0000_0FE0, 16'd64,   -1, 2'd0, -1, 2'd0, -1,  0,    2, 32'h0FE0,  8'd3,  8,    2'd0};
        vt[3]  = '{32'h0000_0000, 16'd0,    -1, 2'd0, -1, 2'd0, -1,  0,    0, 32'h0000,  8'd0,  0,    2'd0};
        vt[4]  = '{32'h0000_1003, 16'd1,    -1, 2'd0, -1, 2'd0, -1,  0,    1, 32'h1000,  8'd0,  1,    2'd0};
        vt[5]  = '{32'h0000_0000, 16'd200,   2, 2'd2,  4, 2'd3, -1,  0,    1, 32'h0000,  8'd15, 16,   2'd2};
        vt[6]  = '{32'h0000_0100, 16'd64,   -1, 2'd0, -1, 2'd0,  7,  0,    1, 32'h0100,  8'd7,  8,    2'd2};
        vt[7]  = '{32'h0000_0000, 16'd256,  -1, 2'd0, -1, 2'd0,  3,  0,    1, 32'h0000,  8'd15, 16,   2'd2};
        vt[8]  = '{32'h0000_0000, 16'd256,  15, 2'd3, -1, 2'd0, -1,  0,    1, 32'h0000,  8'd15, 16,   2'd3};
        vt[9]  = '{32'h0000_0040, 16'd24,    1, 2'd1, -1, 2'd0, -1,  0,    1, 32'h0040,  8'd2,  3,    2'd0};
        vt[10] = '{32'h0000_0FF8, 16'd17,   -1, 2'd0, -1, 2'd0, -1,  0,    2, 32'h0FF8,  8'd0,  3,    2'd0};
        vt[11] = '{32'h0000_0000, 16'd200,  20, 2'd3, -1, 2'd0, -1,  0,    2, 32'h0000,  8'd15, 25,   2'd3};
        vt[12] = '{32'h0000_0000, 16'hFFFF, -1, 2'd0, -1, 2'd0, -1,  0,  512, 32'h0000,  8'd15, 8192, 2'd0};
        vt[13] = '{32'h0000_1FF9, 16'd16,   -1, 2'd0, -1, 2'd0, -1,  0,    2, 32'h1FF8,  8'd0,  2,    2'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values(1'b0);
        rst = 1'b0;
        #1;
        check_reset_values(1'b1);
        chk("arsize", 64'(arsize), 64'(3));
        chk("arburst", 64'(arburst), 64'(1));
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            inj_e1 = vt[i].e1; inj_r1 = vt[i].r1;
            inj_e2 = vt[i].e2; inj_r2 = vt[i].r2;
            inj_flip = vt[i].flip;
            run_cmd(vt[i].addr, vt[i].nbytes, vt[i].stall, -1, n_ar, f_addr, f_len, n_beats, resp);
            chk("vec_nar", 64'(n_ar), 64'(vt[i].x_nar));
            if (vt[i].x_nar > 0) begin
                chk("vec_first_addr", 64'(f_addr), 64'(vt[i].x_addr));
                chk("vec_first_len", 64'(f_len), 64'(vt[i].x_len));
            end
            chk("vec_beats", 64'(n_beats), 64'(vt[i].x_beats));
            chk("vec_resp", 64'(resp), 64'(vt[i].x_resp));
        end

        // Leave a non-zero done_resp behind, then reset in the middle of a burst
        inj_e1 = 0; inj_r1 = 2'd3; inj_e2 = -1; inj_flip = -1;
        run_cmd(32'h0000_0200, 16'd8, 0, -1, n_ar, f_addr, f_len, n_beats, resp);
        chk("pre_rst_resp", 64'(resp), 64'(3));
        inj_e1 = -1;
        run_cmd(32'h0000_0000, 16'd200, 3, 10, n_ar, f_addr, f_len, n_beats, resp);
        chk("abort_beats", 64'(n_beats), 64'(10));
        rst = 1'b1; rvalid = 1'b1; out_ready = 1'b1; arready = 1'b1; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values(1'b0);
        rst = 1'b0; rvalid = 1'b0; cmd_valid = 1'b0; arready = 1'b0;
        #1;
        check_reset_values(1'b1);
        @(negedge clk);
        run_cmd(32'h0000_2000, 16'd40, 0, -1, n_ar, f_addr, f_len, n_beats, resp);
        chk("post_rst_nar", 64'(n_ar), 64'(1));
        chk("post_rst_beats", 64'(n_beats), 64'(5));
        chk("post_rst_resp", 64'(resp), 64'(0));

        for (int i = 0; i < 25; i++) begin
            a_rnd = $urandom;
            if ($urandom_range(0, 1) == 1) a_rnd[31:13] = '0;
            inj_e1   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 90)) : -1;
            inj_r1   = 2'($urandom_range(1, 3));
            inj_e2   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 90)) : -1;
            inj_r2   = 2'($urandom_range(1, 3));
            inj_flip = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 90)) : -1;
            run_cmd(a_rnd, 16'($urandom_range(0, 700)), 0, -1, n_ar, f_addr, f_len, n_beats, resp);
            chk("rand_nar", 64'(n_ar), 64'(exp_nb));
            chk("rand_beats", 64'(n_beats), 64'(exp_beats));
            chk("rand_resp", 64'(resp), 64'(exp_resp));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
